// File: rtl/ct_ciu_age_arb.sv
// Age-ordered arbiter for CIU request buffers: owns entry valid bits and an age
// matrix, and presents the oldest requesting entry on a registered, holdable grant.
module ct_ciu_age_arb #(
  parameter int DEPTH = 24,
  parameter int IDX_W = 5
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             alloc_vld,
  input  logic [IDX_W-1:0] alloc_idx,
  input  logic [DEPTH-1:0] free_vec,
  input  logic [DEPTH-1:0] req_vld,
  input  logic             grant_rdy,
  output logic             grant_vld,
  output logic [DEPTH-1:0] grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic [DEPTH-1:0] entry_vld,
  output logic             full,
  output logic             empty
);

  // age[i][j] = 1 means entry j is older than entry i
  logic [DEPTH-1:0] age     [DEPTH];
  logic [DEPTH-1:0] age_nxt [DEPTH];

  logic [DEPTH-1:0] alloc_oh;
  logic [DEPTH-1:0] survive;
  logic [DEPTH-1:0] entry_vld_nxt;
  logic [DEPTH-1:0] elig;
  logic [DEPTH-1:0] sel;
  logic [IDX_W-1:0] sel_idx;
  logic             accept;
  logic             hold;
  logic             held_ok;
  logic             grant_vld_nxt;
  logic [DEPTH-1:0] grant_oh_nxt;
  logic [IDX_W-1:0] grant_idx_nxt;

  // Bookkeeping: free is applied before allocate, so a same-index pair ends youngest
  always_comb begin
    alloc_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      alloc_oh[i] = alloc_vld && (int'(alloc_idx) == i);
    end
    survive       = entry_vld & ~free_vec;
    entry_vld_nxt = survive | alloc_oh;
    for (int i = 0; i < DEPTH; i++) begin
      age_nxt[i] = alloc_oh[i] ? (survive & ~alloc_oh)
                               : (age[i] & ~free_vec & ~alloc_oh);
    end
  end

  // Oldest-select: the accepted entry sits out the load in the same cycle
  always_comb begin
    accept  = grant_vld & grant_rdy;
    elig    = req_vld & entry_vld & ~(accept ? grant_oh : '0);
    sel     = '0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = elig[i] & ~|(elig & age[i]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) sel_idx = sel_idx | IDX_W'(i);
    end
  end

  always_comb begin
    hold          = grant_vld & ~grant_rdy;
    held_ok       = |(grant_oh & req_vld & entry_vld & ~free_vec);
    grant_vld_nxt = grant_vld;
    grant_oh_nxt  = grant_oh;
    grant_idx_nxt = grant_idx;
    if (hold) begin
      if (!held_ok) begin
        grant_vld_nxt = 1'b0;
        grant_oh_nxt  = '0;
        grant_idx_nxt = '0;
      end
    end else begin
      grant_vld_nxt = |sel;
      grant_oh_nxt  = sel;
      grant_idx_nxt = sel_idx;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      entry_vld <= '0;
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
      grant_vld <= 1'b0;
      grant_oh  <= '0;
      grant_idx <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
    end else begin
      entry_vld <= entry_vld_nxt;
      for (int i = 0; i < DEPTH; i++) age[i] <= age_nxt[i];
      grant_vld <= grant_vld_nxt;
      grant_oh  <= grant_oh_nxt;
      grant_idx <= grant_idx_nxt;
      full      <= &entry_vld_nxt;
      empty     <= ~|entry_vld_nxt;
    end
  end

  // Allocation must target an in-range entry that is free (or freed this cycle)
  assert property (@(posedge forever_cpuclk) disable iff (cpurst)
    alloc_vld |-> |alloc_oh);
  assert property (@(posedge forever_cpuclk) disable iff (cpurst)
    !(|(alloc_oh & entry_vld & ~free_vec)));

endmodule

// File: doc/ct_ciu_age_arb.md
Name: ct_ciu_age_arb

Overview:
- Parametrised age-ordered arbiter for CIU request buffers such as SNB, SAB and VB.
- Owns its age matrix internally, so callers no longer supply per-entry age vectors.
- Each cycle it selects the oldest requesting valid entry and presents it on a registered grant port with a valid/ready hold handshake.
- Adds allocate/free bookkeeping, occupancy flags and grant retention under backpressure, none of which a purely combinational selector provides.

Parameters:
- DEPTH, 24: number of entries; legal range 2..64.
- IDX_W, 5: width of an entry index; must be at least clog2(DEPTH).

Ports:
- forever_cpuclk  in  1  clock.
- cpurst  in  1  synchronous, active-high reset.
- alloc_vld  in  1  allocate the entry given by alloc_idx this cycle.
- alloc_idx  in  IDX_W  index of the entry being allocated (binary).
- free_vec  in  DEPTH  entries released this cycle, one bit per entry.
- req_vld  in  DEPTH  per-entry arbitration request.
- grant_rdy  in  1  consumer accepts the current grant.
- grant_vld  out  1  a grant is presented.
- grant_oh  out  DEPTH  one-hot granted entry.
- grant_idx  out  IDX_W  binary index of the granted entry.
- entry_vld  out  DEPTH  allocated-entry vector.
- full  out  1  all entries are valid (registered).
- empty  out  1  no entry is valid (registered).

Behaviour:
- State:
  - entry_vld[DEPTH-1:0].
  - Age matrix age[i][j]: a 1 means entry j is older than entry i. The diagonal is always 0.
  - Grant registers: grant_vld, grant_oh, grant_idx.
- Reset (cpurst=1 at clock edge):
  - entry_vld=0 and age=0.
  - grant_vld=0, grant_oh=0, grant_idx=0.
  - full=0, empty=1.
  - All inputs are ignored in a reset cycle.
- Free: entry_vld[j] is cleared for every set bit of free_vec. Column j of every row is cleared.
- Allocate (alloc_vld=1, index a):
  - entry_vld[a] is set.
  - Row a is loaded with (entry_vld & ~free_vec), with bit a forced to 0. All surviving entries are therefore older than a.
  - Column a of all other rows is cleared.
- Same-cycle free and allocate of the same index: free is applied first, then allocate. The entry ends valid and is the youngest.
- Illegal cases (simulation assertion; RTL behaviour undefined):
  - alloc_vld with alloc_idx >= DEPTH.
  - Allocating an entry that is valid and not freed in the same cycle.
- Eligibility: elig = req_vld & entry_vld.
- Oldest select: sel[i] = elig[i] & ~|(elig & age[i]). Because the age order is total, sel is at most one-hot.
- Grant register update, evaluated in order:
  1. Hold. If grant_vld=1, grant_rdy=0, and the held entry still has elig=1 and is not in free_vec, the grant is held unchanged, even if an older entry begins requesting.
  2. Drop. If grant_vld=1, grant_rdy=0, and the held entry lost elig or is freed this cycle, the next cycle has grant_vld=0. Re-arbitration happens the cycle after that.
  3. Load. Otherwise (no grant, or grant_rdy=1), grant_vld<=|sel and grant_oh<=sel. grant_idx<=encode(sel), or 0 when sel=0.
- Grant latency and exclusion:
  - A request becomes visible on grant_vld one cycle after it is eligible.
  - The entry accepted (grant_vld & grant_rdy) is excluded from the load that occurs in the same cycle. It becomes re-eligible the following cycle only if the caller keeps req_vld set.
- Occupancy flags:
  - full is registered: &entry_vld_next.
  - empty is registered: ~|entry_vld_next.
- Throughput: back-to-back grants, one per cycle, whenever grant_rdy=1.
- Wrap-around: none. Age is relative only, so allocating and freeing indefinitely never saturates.
- Alloc or free of a non-granted entry while a grant is held does not disturb the hold.

Test Plan:
- Reset with alloc_vld=1, req_vld all-ones asserted in the same cycle -> entry_vld=0, grant_vld=0, empty=1, full=0 on the next cycle.
- Allocate entries 5, 2, 9 in consecutive cycles; req_vld sets bits 2, 5 and 9; grant_rdy=1 -> grant_idx sequence 5, 2, 9. When the caller clears req_vld for the accepted entry, grant_vld=0 afterwards.
- Allocate entries 3 then 7; request only 7; grant_rdy=0 for 4 cycles; entry 3 raises its request at cycle 2 -> grant_idx=7 is held all 4 cycles. After acceptance, grant_idx=3.
- Allocate 0 then 1; hold a grant on entry 0 with grant_rdy=0; free_vec=0x1 -> grant_vld=0 next cycle. One cycle later, grant_idx=1.
- Fill all 24 entries in order 0..23 -> full=1. Then free entry 0 and allocate entry 0 in the same cycle; request entries 0 and 23 -> grant_idx=23, because the reallocated entry 0 is now the youngest.
- Parameter sweep DEPTH=2, IDX_W=1 and DEPTH=64, IDX_W=6, random alloc/free/req -> scoreboard FIFO-age model matches grant_idx every cycle, and grant_oh is always one-hot or zero.
